// File: rtl/mem_stage.sv
// Memory pipeline stage: latches EX results, waits for the data-memory read or write
// response when needed, formats load data and hands the result to WB over valid/ready.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        valid_out,
  input  logic        ready_in,
  input  logic        dmem_axi_arvalid_EX,
  input  logic        dmem_axi_awvalid_EX,
  input  logic        dmem_axi_wvalid_EX,
  input  logic [31:0] dmem_axi_rdata,
  input  logic [1:0]  dmem_axi_rresp,
  input  logic        dmem_axi_rvalid,
  output logic        dmem_axi_rready,
  input  logic [1:0]  dmem_axi_bresp,
  input  logic        dmem_axi_bvalid,
  output logic        dmem_axi_bready,
  input  logic [31:0] PC_EX,
  input  logic [31:0] IR_EX,
  input  logic [31:0] IM_EX,
  input  logic [5:0]  rd_addr_EX,
  input  logic [31:0] rd_data_EX,
  input  logic        rd_access_EX,
  input  logic [2:0]  wb_src_EX,
  input  logic [2:0]  MEM_op_EX,
  input  logic [1:0]  addr_EX,
  input  logic        illegal_inst_EX,
  input  logic        maligned_data_addr_EX,
  input  logic        maligned_inst_addr_EX,
  input  logic [1:0]  imem_axi_rresp_EX,
  output logic [31:0] PC_MEM,
  output logic [31:0] IR_MEM,
  output logic [31:0] IM_MEM,
  output logic [5:0]  rd_addr_MEM,
  output logic [31:0] rd_data_MEM,
  output logic        rd_access_MEM,
  output logic        illegal_inst_MEM,
  output logic        maligned_data_addr_MEM,
  output logic        maligned_inst_addr_MEM,
  output logic [1:0]  imem_axi_rresp_MEM,
  output logic [1:0]  dmem_axi_resp_MEM,
  output logic        ld_pending_MEM
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RA_W   = 6;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned RESP_W = 2;

  localparam logic [2:0] SEL_MEM  = 3'd1;
  localparam logic [2:0] MEM_LB   = 3'd0;
  localparam logic [2:0] MEM_LH   = 3'd1;
  localparam logic [2:0] MEM_LW   = 3'd2;
  localparam logic [2:0] MEM_LBU  = 3'd4;
  localparam logic [2:0] MEM_LHU  = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_R = 2'd1,
    WAIT_B = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     ir_q, ir_d;
  logic [XLEN-1:0]     im_q, im_d;
  logic [RA_W-1:0]     rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]     rd_data_q, rd_data_d;
  logic                rd_access_q, rd_access_d;
  logic                illegal_q, illegal_d;
  logic                mal_data_q, mal_data_d;
  logic                mal_inst_q, mal_inst_d;
  logic [RESP_W-1:0]   imem_resp_q, imem_resp_d;
  logic [RESP_W-1:0]   dmem_resp_q, dmem_resp_d;
  logic [OP_W-1:0]     mem_op_q, mem_op_d;
  logic [1:0]          addr_q, addr_d;

  logic                ex_req_busy;
  logic                accept;

  // Align the addressed byte/half to bit 0, then extend according to the load type.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] rdata,
                                               input logic [1:0]      addr,
                                               input logic [OP_W-1:0] op);
    logic [XLEN-1:0] s;
    s = rdata >> {addr, 3'b000};
    case (op)
      MEM_LB:  fmt_load = {{24{s[7]}}, s[7:0]};
      MEM_LBU: fmt_load = {24'd0, s[7:0]};
      MEM_LH:  fmt_load = {{16{s[15]}}, s[15:0]};
      MEM_LHU: fmt_load = {16'd0, s[15:0]};
      MEM_LW:  fmt_load = s;
      default: fmt_load = s;
    endcase
  endfunction

  // EX must not advance while it still has a request channel outstanding.
  assign ex_req_busy = dmem_axi_arvalid_EX | dmem_axi_awvalid_EX | dmem_axi_wvalid_EX;
  assign ready_out   = ((state_q == IDLE) | ((state_q == DONE) & ready_in)) & ~ex_req_busy;
  assign accept      = valid_in & ready_out;

  assign valid_out       = (state_q == DONE);
  assign dmem_axi_rready = (state_q == WAIT_R);
  assign dmem_axi_bready = (state_q == WAIT_B);
  assign ld_pending_MEM  = (state_q == WAIT_R);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    im_d        = im_q;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    rd_access_d = rd_access_q;
    illegal_d   = illegal_q;
    mal_data_d  = mal_data_q;
    mal_inst_d  = mal_inst_q;
    imem_resp_d = imem_resp_q;
    dmem_resp_d = dmem_resp_q;
    mem_op_d    = mem_op_q;
    addr_d      = addr_q;

    case (state_q)
      WAIT_R: begin
        if (dmem_axi_rvalid) begin
          rd_data_d   = (dmem_axi_rresp != 2'b00) ? '0
                        : fmt_load(dmem_axi_rdata, addr_q, mem_op_q);
          dmem_resp_d = dmem_axi_rresp;
          state_d     = DONE;
        end
      end
      WAIT_B: begin
        if (dmem_axi_bvalid) begin
          dmem_resp_d = dmem_axi_bresp;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (ready_in) begin
          state_d     = IDLE;
          pc_d        = '0;
          ir_d        = '0;
          im_d        = '0;
          rd_addr_d   = '0;
          rd_data_d   = '0;
          rd_access_d = 1'b0;
          illegal_d   = 1'b0;
          mal_data_d  = 1'b0;
          mal_inst_d  = 1'b0;
          imem_resp_d = '0;
          dmem_resp_d = '0;
          mem_op_d    = '0;
          addr_d      = '0;
        end
      end
      default: ;
    endcase

    // A new instruction overrides the drain above, giving zero-bubble handoff.
    if (accept) begin
      pc_d        = PC_EX;
      ir_d        = IR_EX;
      im_d        = IM_EX;
      rd_addr_d   = rd_addr_EX;
      rd_access_d = rd_access_EX;
      illegal_d   = illegal_inst_EX;
      mal_data_d  = maligned_data_addr_EX;
      mal_inst_d  = maligned_inst_addr_EX;
      imem_resp_d = imem_axi_rresp_EX;
      dmem_resp_d = 2'b00;
      mem_op_d    = MEM_op_EX;
      addr_d      = addr_EX;
      if (wb_src_EX == SEL_MEM) begin
        rd_data_d = '0;
        state_d   = rd_access_EX ? WAIT_R : WAIT_B;
      end else begin
        rd_data_d = rd_data_EX;
        state_d   = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      im_q        <= '0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      rd_access_q <= 1'b0;
      illegal_q   <= 1'b0;
      mal_data_q  <= 1'b0;
      mal_inst_q  <= 1'b0;
      imem_resp_q <= '0;
      dmem_resp_q <= '0;
      mem_op_q    <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      im_q        <= im_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      rd_access_q <= rd_access_d;
      illegal_q   <= illegal_d;
      mal_data_q  <= mal_data_d;
      mal_inst_q  <= mal_inst_d;
      imem_resp_q <= imem_resp_d;
      dmem_resp_q <= dmem_resp_d;
      mem_op_q    <= mem_op_d;
      addr_q      <= addr_d;
    end
  end

  assign PC_MEM                 = pc_q;
  assign IR_MEM                 = ir_q;
  assign IM_MEM                 = im_q;
  assign rd_addr_MEM            = rd_addr_q;
  assign rd_data_MEM            = rd_data_q;
  assign rd_access_MEM          = rd_access_q;
  assign illegal_inst_MEM       = illegal_q;
  assign maligned_data_addr_MEM = mal_data_q;
  assign maligned_inst_addr_MEM = mal_inst_q;
  assign imem_axi_rresp_MEM     = imem_resp_q;
  assign dmem_axi_resp_MEM      = dmem_resp_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, formatted loads, stores,
// back-pressure, EX request stall and reset abandoning a pending load.
module tb_mem_stage;

  localparam logic [2:0] SEL_ALU = 3'd0;
  localparam logic [2:0] SEL_MEM = 3'd1;
  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LH  = 3'd1;
  localparam logic [2:0] MEM_LW  = 3'd2;
  localparam logic [2:0] MEM_LHU = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, ready_out, valid_out, ready_in;
  logic        arvalid_ex, awvalid_ex, wvalid_ex;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        rvalid, rready, bvalid, bready;
  logic [31:0] pc_ex, ir_ex, im_ex, rd_data_ex;
  logic [5:0]  rd_addr_ex;
  logic        rd_access_ex;
  logic [2:0]  wb_src_ex, mem_op_ex;
  logic [1:0]  addr_ex, imem_rresp_ex;
  logic        illegal_ex, mal_data_ex, mal_inst_ex;
  logic [31:0] pc_mem, ir_mem, im_mem, rd_data_mem;
  logic [5:0]  rd_addr_mem;
  logic        rd_access_mem, illegal_mem, mal_data_mem, mal_inst_mem, ld_pending;
  logic [1:0]  imem_rresp_mem, dmem_resp_mem;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_out(ready_out), .valid_out(valid_out), .ready_in(ready_in),
    .dmem_axi_arvalid_EX(arvalid_ex), .dmem_axi_awvalid_EX(awvalid_ex),
    .dmem_axi_wvalid_EX(wvalid_ex),
    .dmem_axi_rdata(rdata), .dmem_axi_rresp(rresp), .dmem_axi_rvalid(rvalid),
    .dmem_axi_rready(rready),
    .dmem_axi_bresp(bresp), .dmem_axi_bvalid(bvalid), .dmem_axi_bready(bready),
    .PC_EX(pc_ex), .IR_EX(ir_ex), .IM_EX(im_ex), .rd_addr_EX(rd_addr_ex),
    .rd_data_EX(rd_data_ex), .rd_access_EX(rd_access_ex), .wb_src_EX(wb_src_ex),
    .MEM_op_EX(mem_op_ex), .addr_EX(addr_ex), .illegal_inst_EX(illegal_ex),
    .maligned_data_addr_EX(mal_data_ex), .maligned_inst_addr_EX(mal_inst_ex),
    .imem_axi_rresp_EX(imem_rresp_ex),
    .PC_MEM(pc_mem), .IR_MEM(ir_mem), .IM_MEM(im_mem), .rd_addr_MEM(rd_addr_mem),
    .rd_data_MEM(rd_data_mem), .rd_access_MEM(rd_access_mem),
    .illegal_inst_MEM(illegal_mem), .maligned_data_addr_MEM(mal_data_mem),
    .maligned_inst_addr_MEM(mal_inst_mem), .imem_axi_rresp_MEM(imem_rresp_mem),
    .dmem_axi_resp_MEM(dmem_resp_mem), .ld_pending_MEM(ld_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [2:0] wb, input logic acc, input logic [2:0] op,
                        input logic [1:0] a, input logic [5:0] rd, input logic [31:0] d);
    wb_src_ex = wb; rd_access_ex = acc; mem_op_ex = op; addr_ex = a;
    rd_addr_ex = rd; rd_data_ex = d;
  endtask

  initial begin
    reset = 1'b1; valid_in = 0; ready_in = 0;
    arvalid_ex = 0; awvalid_ex = 0; wvalid_ex = 0;
    rdata = '0; rresp = '0; bresp = '0; rvalid = 0; bvalid = 0;
    pc_ex = '0; ir_ex = '0; im_ex = '0; rd_data_ex = '0; rd_addr_ex = '0;
    rd_access_ex = 0; wb_src_ex = SEL_ALU; mem_op_ex = '0; addr_ex = '0;
    imem_rresp_ex = '0; illegal_ex = 0; mal_data_ex = 0; mal_inst_ex = 0;

    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_rd_data", rd_data_mem, 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_ld_pending", 32'(ld_pending), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ALU pass-through then drain to IDLE
    ready_in = 1; valid_in = 1; pc_ex = 32'h100; imem_rresp_ex = 2'b01;
    set_ex(SEL_ALU, 1, MEM_LW, 2'b00, 6'd5, 32'h12345678);
    #1 chk("alu_ready_out", 32'(ready_out), 32'd1);
    tick();
    chk("alu_valid_out", 32'(valid_out), 32'd1);
    chk("alu_rd_data", rd_data_mem, 32'h12345678);
    chk("alu_rd_addr", 32'(rd_addr_mem), 32'd5);
    chk("alu_pc", pc_mem, 32'h100);
    chk("alu_imem_resp", 32'(imem_rresp_mem), 32'd1);
    valid_in = 0; imem_rresp_ex = 2'b00;
    tick();
    chk("alu_drain_valid", 32'(valid_out), 32'd0);
    chk("alu_drain_data", rd_data_mem, 32'd0);
    chk("alu_drain_pc", pc_mem, 32'd0);

    // LB at byte 3 with response on the third WAIT_R cycle
    valid_in = 1; ready_in = 0;
    set_ex(SEL_MEM, 1, MEM_LB, 2'b11, 6'd7, 32'hAAAA_AAAA);
    tick();
    valid_in = 0;
    chk("lb_rready_c1", 32'(rready), 32'd1);
    chk("lb_ld_pending", 32'(ld_pending), 32'd1);
    chk("lb_rd_addr", 32'(rd_addr_mem), 32'd7);
    chk("lb_rd_access", 32'(rd_access_mem), 32'd1);
    chk("lb_valid_wait", 32'(valid_out), 32'd0);
    bvalid = 1; bresp = 2'b11;
    tick();
    chk("lb_rready_c2", 32'(rready), 32'd1);
    bvalid = 0; bresp = 2'b00;
    tick();
    chk("lb_rready_c3", 32'(rready), 32'd1);
    rvalid = 1; rdata = 32'h80FF_0000; rresp = 2'b00;
    tick();
    rvalid = 0;
    chk("lb_valid_out", 32'(valid_out), 32'd1);
    chk("lb_data", rd_data_mem, 32'hFFFF_FF80);
    chk("lb_rready_done", 32'(rready), 32'd0);
    chk("lb_resp", 32'(dmem_resp_mem), 32'd0);
    tick();
    chk("lb_hold_data", rd_data_mem, 32'hFFFF_FF80);

    // LHU at half 2, accepted zero-bubble from DONE, response immediately
    ready_in = 1; valid_in = 1;
    set_ex(SEL_MEM, 1, MEM_LHU, 2'b10, 6'd8, 32'h0);
    tick();
    valid_in = 0;
    chk("lhu_rready", 32'(rready), 32'd1);
    rvalid = 1; rdata = 32'h80FF_0000;
    tick();
    rvalid = 0;
    chk("lhu_data", rd_data_mem, 32'h0000_80FF);
    chk("lhu_rd_addr", 32'(rd_addr_mem), 32'd8);
    tick();

    // LH at byte 1, sign-extended
    valid_in = 1;
    set_ex(SEL_MEM, 1, MEM_LH, 2'b01, 6'd9, 32'h0);
    tick();
    valid_in = 0; rvalid = 1; rdata = 32'h00AB_CD00;
    tick();
    rvalid = 0;
    chk("lh_data", rd_data_mem, 32'hFFFF_ABCD);
    tick();

    // LW with error response: data forced to zero, resp reported
    valid_in = 1;
    set_ex(SEL_MEM, 1, MEM_LW, 2'b00, 6'd10, 32'h0);
    tick();
    valid_in = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    tick();
    rvalid = 0; rresp = 2'b00;
    chk("lwerr_data", rd_data_mem, 32'd0);
    chk("lwerr_resp", 32'(dmem_resp_mem), 32'd2);
    tick();

    // Store with misaligned flag; stray rvalid ignored; bvalid on second cycle
    valid_in = 1; mal_data_ex = 1;
    set_ex(SEL_MEM, 0, MEM_LW, 2'b01, 6'd0, 32'h5555_5555);
    tick();
    valid_in = 0; mal_data_ex = 0;
    chk("st_bready_c1", 32'(bready), 32'd1);
    chk("st_rready", 32'(rready), 32'd0);
    chk("st_mal_data", 32'(mal_data_mem), 32'd1);
    rvalid = 1;
    tick();
    rvalid = 0;
    chk("st_bready_c2", 32'(bready), 32'd1);
    chk("st_ignore_rvalid", 32'(valid_out), 32'd0);
    bvalid = 1; bresp = 2'b10;
    tick();
    bvalid = 0; bresp = 2'b00;
    chk("st_valid_out", 32'(valid_out), 32'd1);
    chk("st_resp", 32'(dmem_resp_mem), 32'd2);
    chk("st_rd_access", 32'(rd_access_mem), 32'd0);
    chk("st_bready_done", 32'(bready), 32'd0);
    tick();

    // Back-to-back ALU ops, then back-pressure
    valid_in = 1;
    set_ex(SEL_ALU, 1, MEM_LW, 2'b00, 6'd1, 32'hA1A1_A1A1);
    tick();
    chk("b2b_1_data", rd_data_mem, 32'hA1A1_A1A1);
    #1 chk("b2b_ready_out", 32'(ready_out), 32'd1);
    rd_data_ex = 32'hA2A2_A2A2;
    tick();
    chk("b2b_2_valid", 32'(valid_out), 32'd1);
    chk("b2b_2_data", rd_data_mem, 32'hA2A2_A2A2);
    ready_in = 0; rd_data_ex = 32'hA3A3_A3A3;
    #1 chk("bp_ready_out", 32'(ready_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(valid_out), 32'd1);
      chk("bp_frozen", rd_data_mem, 32'hA2A2_A2A2);
    end
    ready_in = 1;
    tick();
    chk("b2b_3_data", rd_data_mem, 32'hA3A3_A3A3);
    valid_in = 0;
    tick();
    chk("b2b_idle", 32'(valid_out), 32'd0);

    // EX still has a read request outstanding
    valid_in = 1; arvalid_ex = 1;
    set_ex(SEL_ALU, 1, MEM_LW, 2'b00, 6'd2, 32'hC0DE_0001);
    #1 chk("ar_ready_out", 32'(ready_out), 32'd0);
    tick();
    chk("ar_no_accept", 32'(valid_out), 32'd0);
    arvalid_ex = 0;
    #1 chk("ar_ready_after", 32'(ready_out), 32'd1);
    tick();
    chk("ar_accept_data", rd_data_mem, 32'hC0DE_0001);
    valid_in = 0;
    tick();

    // Reset while waiting for read data, then late rvalid
    valid_in = 1;
    set_ex(SEL_MEM, 1, MEM_LW, 2'b00, 6'd11, 32'h0);
    tick();
    valid_in = 0;
    chk("rstw_rready_pre", 32'(rready), 32'd1);
    #2 reset = 1;
    #1;
    chk("rstw_rready_async", 32'(rready), 32'd0);
    chk("rstw_ld_pending", 32'(ld_pending), 32'd0);
    chk("rstw_rd_addr", 32'(rd_addr_mem), 32'd0);
    tick();
    reset = 0; rvalid = 1; rdata = 32'h1234_5678;
    tick();
    chk("rstw_late_rready", 32'(rready), 32'd0);
    chk("rstw_late_valid", 32'(valid_out), 32'd0);
    chk("rstw_late_data", rd_data_mem, 32'd0);
    rvalid = 0;
    tick();
    chk("rstw_idle_ready", 32'(ready_out), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
